// File: rtl/ks59_mul_arbiter.sv
// Two-requester front end for a shared combinational 59-bit carry-less multiplier.
// Operands are held for MUL_CYCLES cycles, then the product is returned with the winner's tag.
module ks59_mul_arbiter #(
    parameter int W          = 59,
    parameter int MUL_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic [2*W-2:0] mul_d,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*W-2:0] rsp_d
);

    // Handshakes: a transfer happens on a clock edge where valid and ready are both 1.
    // req*_ready is combinational and only ever high in IDLE; rsp_valid holds until rsp_ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(MUL_CYCLES - 1);

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           ptr_q, ptr_d;
    logic [W-1:0]   mul_a_q, mul_a_d;
    logic [W-1:0]   mul_b_q, mul_b_d;
    logic [2*W-2:0] rsp_d_q, rsp_d_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic           gnt_any;
    logic           gnt_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_d_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_d_q     <= rsp_d_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        rsp_d_d     = rsp_d_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        gnt_any     = req0_valid | req1_valid;
        // ptr_q == 1 means requester 1 wins a tie.
        gnt_id      = req1_valid & (~req0_valid | ptr_q);

        case (state_q)
            IDLE: begin
                if (gnt_any && !rst) begin
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    mul_a_d    = gnt_id ? req1_a : req0_a;
                    mul_b_d    = gnt_id ? req1_b : req0_b;
                    rsp_id_d   = gnt_id;
                    cnt_d      = '0;
                    ptr_d      = ~gnt_id;
                    state_d    = MUL;
                end
            end
            MUL: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    rsp_d_d     = mul_d;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_d     = rsp_d_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_ks59_mul_arbiter.sv
// Directed bench for ks59_mul_arbiter: a carry-less multiplier stand-in drives mul_d,
// expected products are hand-computed constants queued in a scoreboard.
module tb_ks59_mul_arbiter;

    localparam int W  = 59;
    localparam int MC = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           req0_valid = 1'b0, req1_valid = 1'b0;
    logic           req0_ready, req1_ready;
    logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-2:0] mul_d;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic           rsp_id;
    logic [2*W-2:0] rsp_d;

    int n_checks = 0;
    int n_pass   = 0;

    // {id, product}
    logic [2*W-1:0] exp_q[$];

    typedef struct {
        bit             id;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-2:0] exp_d;
    } vec_t;
    vec_t vecs[6];

    ks59_mul_arbiter #(.W(W), .MUL_CYCLES(MC)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_d(mul_d),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_d(rsp_d)
    );

    // ---- clock / reset ----
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference carry-less multiplier standing in for the ks59 instance.
    function automatic logic [2*W-2:0] clmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-2:0] r;
        r = '0;
        for (int i = 0; i < W; i++)
            if (b[i]) r = r ^ ((2*W-1)'(a) << i);
        return r;
    endfunction

    always_comb mul_d = clmul(mul_a, mul_b);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---- driver tasks ----
    task automatic drive_req(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
    endtask

    task automatic wait_grant(input bit id, input string name);
        int n;
        n = 0;
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check({name, " ready"}, 128'(id ? req1_ready : req0_ready), 128'(1));
        check({name, " other ready"}, 128'(id ? req0_ready : req1_ready), 128'(0));
    endtask

    // Called at the first negedge (+#1) after the accept edge.
    task automatic wait_rsp(input string name);
        int lat;
        logic [2*W-1:0] e;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        check({name, " latency"}, 128'(lat), 128'(MC));
        if (exp_q.size() == 0) begin
            check({name, " scoreboard empty"}, 128'(1), 128'(0));
        end else begin
            e = exp_q.pop_front();
            check({name, " rsp_d"}, 128'(rsp_d), 128'(e[2*W-2:0]));
            check({name, " rsp_id"}, 128'(rsp_id), 128'(e[2*W-1]));
        end
        if (rsp_ready) begin
            @(negedge clk); #1;
            check({name, " rsp_valid drop"}, 128'(rsp_valid), 128'(0));
        end
    endtask

    task automatic run_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-2:0] exp_d, input string name);
        drive_req(id, a, b);
        wait_grant(id, name);
        exp_q.push_back({id, exp_d});
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check({name, " mul_a"}, 128'(mul_a), 128'(a));
        check({name, " mul_b"}, 128'(mul_b), 128'(b));
        wait_rsp(name);
    endtask

    // ---- stimulus ----
    initial begin
        logic [2*W-2:0] held_d;
        logic           held_id;
        logic           bad_valid, bad_data, bad_ready, seen_rsp;
        int             n_rsp, n_gnt, cyc;
        bit             gnt_order[4];

        vecs[0] = '{id: 1'b0, a: 59'h3,  b: 59'h3,   exp_d: 117'h5};
        vecs[1] = '{id: 1'b1, a: 59'(1) << 58, b: 59'(1) << 58, exp_d: 117'(1) << 116};
        vecs[2] = '{id: 1'b0, a: 59'h2,  b: 59'h3,   exp_d: 117'h6};
        vecs[3] = '{id: 1'b1, a: 59'h7,  b: 59'h7,   exp_d: 117'h15};
        vecs[4] = '{id: 1'b0, a: 59'hFF, b: 59'h101, exp_d: 117'hFFFF};
        vecs[5] = '{id: 1'b1, a: 59'h1,  b: {W{1'b1}}, exp_d: 117'({W{1'b1}})};

        // Reset state, with req0 asserted while rst is high.
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst req0_ready", 128'(req0_ready), 128'(0));
        check("rst rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst rsp_id", 128'(rsp_id), 128'(0));
        check("rst rsp_d", 128'(rsp_d), 128'(0));
        check("rst mul_a", 128'(mul_a), 128'(0));
        check("rst mul_b", 128'(mul_b), 128'(0));
        req0_valid = 1'b0;
        rst = 1'b0;

        // Table-driven single operations.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp_d, $sformatf("vec%0d", i));
        end

        // Contention: both requesters continuously valid, grants must alternate from 0.
        do_reset();
        rsp_ready = 1'b1;
        drive_req(1'b0, 59'h2, 59'h3);
        drive_req(1'b1, 59'h7, 59'h7);
        n_rsp = 0;
        n_gnt = 0;
        cyc   = 0;
        while (n_rsp < 4 && cyc < 100) begin
            #1;
            if (req0_ready && req1_ready)
                check("contend dual ready", 128'(1), 128'(0));
            if ((req0_ready || req1_ready) && n_gnt < 4) begin
                gnt_order[n_gnt] = req1_ready;
                exp_q.push_back(req1_ready ? {1'b1, 117'h15} : {1'b0, 117'h6});
                n_gnt++;
            end
            if (rsp_valid) begin
                logic [2*W-1:0] e;
                e = exp_q.pop_front();
                check($sformatf("contend rsp%0d", n_rsp), 128'({rsp_id, rsp_d}), 128'(e));
                n_rsp++;
                if (n_rsp == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("contend responses", 128'(n_rsp), 128'(4));
        for (int i = 0; i < 4; i++)
            check($sformatf("contend grant%0d", i), 128'(gnt_order[i]), 128'(i % 2));
        exp_q.delete();

        // Backpressure: rsp_ready low for 10 cycles while req0 stays valid.
        @(negedge clk);
        rsp_ready = 1'b0;
        drive_req(1'b0, 59'h5, 59'h5);
        wait_grant(1'b0, "bp");
        exp_q.push_back({1'b0, 117'h11});
        @(negedge clk); #1;
        wait_rsp("bp");
        held_d    = rsp_d;
        held_id   = rsp_id;
        bad_valid = 1'b0;
        bad_data  = 1'b0;
        bad_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (!rsp_valid) bad_valid = 1'b1;
            if (rsp_d !== held_d || rsp_id !== held_id) bad_data = 1'b1;
            if (req0_ready) bad_ready = 1'b1;
        end
        check("bp rsp_valid held", 128'(bad_valid), 128'(0));
        check("bp rsp stable", 128'(bad_data), 128'(0));
        check("bp req0_ready low", 128'(bad_ready), 128'(0));
        rsp_ready = 1'b1;
        #1;
        check("bp ready before accept", 128'(req0_ready), 128'(0));
        @(negedge clk); #1;
        check("bp regrant", 128'(req0_ready), 128'(1));
        exp_q.push_back({1'b0, 117'h11});
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        wait_rsp("bp second");

        // Reset in the middle of MUL: op is discarded.
        @(negedge clk);
        drive_req(1'b1, 59'h3, 59'h3);
        wait_grant(1'b1, "midrst");
        @(negedge clk);
        req1_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst outputs", 128'({rsp_valid, rsp_id, req0_ready, req1_ready}), 128'(0));
        check("midrst rsp_d", 128'(rsp_d), 128'(0));
        check("midrst mul_ab", 128'({mul_a, mul_b}), 128'(0));
        seen_rsp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (rsp_valid) seen_rsp = 1'b1;
        end
        check("midrst no response", 128'(seen_rsp), 128'(0));
        @(negedge clk);
        run_op(1'b1, 59'h3, 59'h6, 117'hA, "after rst");

        // Operand change right after accept must not reach the multiplier.
        @(negedge clk);
        drive_req(1'b0, 59'h5, 59'h3);
        wait_grant(1'b0, "opchg");
        exp_q.push_back({1'b0, 117'hF});
        @(negedge clk);
        req0_a = 59'h1234567;
        req0_b = 59'h7654321;
        req0_valid = 1'b0;
        #1;
        check("opchg mul_a", 128'(mul_a), 128'(59'h5));
        check("opchg mul_b", 128'(mul_b), 128'(59'h3));
        wait_rsp("opchg");
        check("idle mul_a kept", 128'(mul_a), 128'(59'h5));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
